inv_last_round: RTL and testbench
=================================

# inv_last_round

Iterative inverse of the modified-AES final encryption round. It is the first stage of the modified-AES decryption datapath. It accepts one 128-bit ciphertext block plus the two round keys used by the forward last round, and returns the recovered round-input state. The forward round computes C = K_last ^ ShiftRows(ModAdd(SubBytes(X), K_mod)). This block computes X = InvSubBytes(ModSub(InvShiftRows(C ^ K_last), K_mod)), using a valid/ready handshake on both sides.

## Interface
- No parameters.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  ciphertext block and keys are valid.
- in_ready  output  1  block can accept; high only in IDLE.
- in_data  input  128  ciphertext block C.
- key_last  input  128  key XORed after ShiftRows in the forward round.
- key_mod  input  128  key used by the forward byte-wise modular addition.
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  128  recovered state X.

## Operation
- Byte b(i) = data[127-8i -: 8], for i = 0..15. State is column-major: i = 4*col + row.
- ModSub is applied per byte: (s_i - k_i) mod 256, with no carry between bytes. It is the exact inverse of the forward ModAdd (s_i + k_i) mod 256.
- InvShiftRows: out[r+4c] = in[r+4*((c-r) mod 4)]. Row r rotates right by r.
- InvSubBytes uses the standard AES inverse S-box. Four instances process one column per cycle.
- FSM states: IDLE, SUB, ISB, OUT. Column counter col is 2 bits.
  - IDLE: in_ready=1. On in_valid, latch st <= InvShiftRows(in_data ^ key_last) and km <= key_mod, then go to SUB.
  - SUB: st <= bytewise (st - km) mod 256. Set col <= 0 and go to ISB.
  - ISB: bytes 4col..4col+3 of st <= InvSbox of those bytes. col increments. After col==3, go to OUT.
  - OUT: out_valid=1 and out_data=st. On out_ready, go to IDLE. Otherwise hold st and out_data stable indefinitely.
- Inputs are sampled only on the accepting edge. Later changes to in_data and keys do not affect the block in flight.
- in_valid outside IDLE is ignored. in_ready=0, so no block is lost.
- out_data equals st at all times. It is qualified only by out_valid.

## Timing
- Reset (rst=1 at an edge) does all of the following:
  - state=IDLE, col=0.
  - st=0, km=0, so out_data=0.
  - out_valid=0, in_ready=1 from the following cycle.
- Reset takes priority over every other event, including mid-operation. A block in flight is discarded and out_valid never rises for it.
- Latency: if accept happens at edge E, SUB is done at E+1 and the ISB columns complete at E+2..E+5. out_valid is high after edge E+5.
- If out_ready is already high when out_valid rises, the handoff occurs at edge E+6. in_ready is high after E+6, and the next accept is at E+7 at the earliest. Peak throughput is one block per 7 cycles.
- The output handshake completes on an edge where out_valid && out_ready. out_valid drops after that edge.
- out_valid and in_ready are never high at the same time.
- The four ISB cycles are fixed. There is no early exit for any data value.

## Test plan
- Basic inverse S-box: key_last=0, key_mod=0, in_data=16×0x63 → out_data=16×0x00, with out_valid rising 5 edges after accept.
- Modular subtraction wrap: key_last=0, key_mod=16×0x9D, in_data=16×0x00. The subtraction gives 0x00-0x9D=0x63 → out_data=16×0x00. Then in_data=16×0x64, key_mod=16×0x01 → out_data=16×0x00.
- InvShiftRows and key_last: key_mod=0, key_last=16×0x63. in_data is all 0x00 except byte 1 (row 1, col 0) =0x1F, which becomes 0x7C after the XOR. Expected out_data is all 0x00 except byte 5=0x01.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid rises. out_data and out_valid must stay stable and in_ready must stay 0.
  - A second in_valid pulse in this window is not accepted.
  - Raising out_ready completes the handoff in one edge.
- Reset mid-operation: assert rst during ISB (col=2). Expected after the edge: out_valid=0, out_data=0, in_ready=1. A new block then completes normally with the correct result.
- Back-to-back: hold in_valid and out_ready high with 3 distinct blocks. Results must appear in order, 7 cycles apart, and each must match the software model of the inverse round.

Source files
------------

// File: rtl/inv_last_round.sv
// Inverse of the modified-AES final round: X = InvSubBytes(ModSub(InvShiftRows(C ^ K_last), K_mod)).
// One column of inverse S-boxes per cycle; valid/ready handshake on both sides.
module inv_last_round (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] key_last,
    input  logic [127:0] key_mod,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int unsigned DATA_W = 128;
    localparam int unsigned COL_W  = 32;

    localparam logic [2047:0] INV_SBOX = {
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Entry 0 sits in the top byte, so index by the inverted value.
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX[{~x, 3'b000} +: 8];
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        ISB  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          col_q, col_d;
    logic [DATA_W-1:0]   st_q, st_d;
    logic [DATA_W-1:0]   km_q, km_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;

    logic [DATA_W-1:0]   xk;
    logic [6:0]          col_lsb;
    logic [COL_W-1:0]    col_w;
    logic [COL_W-1:0]    new_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= 2'd0;
            st_q        <= '0;
            km_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            st_q        <= st_d;
            km_q        <= km_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        st_d    = st_q;
        km_d    = km_q;
        xk      = in_data ^ key_last;
        // Column 0 occupies the most significant 32 bits.
        col_lsb = {~col_q, 5'd0};
        col_w   = st_q[col_lsb +: COL_W];
        new_w   = '0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    for (int c = 0; c < 4; c++) begin
                        for (int r = 0; r < 4; r++) begin
                            st_d[127 - 8*(r + 4*c) -: 8] = xk[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
                        end
                    end
                    km_d    = key_mod;
                    state_d = SUB;
                end
            end
            SUB: begin
                for (int i = 0; i < 16; i++) begin
                    st_d[8*i +: 8] = st_q[8*i +: 8] - km_q[8*i +: 8];
                end
                col_d   = 2'd0;
                state_d = ISB;
            end
            ISB: begin
                for (int r = 0; r < 4; r++) begin
                    new_w[31 - 8*r -: 8] = inv_sbox(col_w[31 - 8*r -: 8]);
                end
                st_d[col_lsb +: COL_W] = new_w;
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == OUT);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = st_q;

endmodule

// File: tb/tb_inv_last_round.sv
// Bench for inv_last_round: directed and random blocks against a reference built from GF(2^8) arithmetic.
module tb_inv_last_round;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] key_last;
    logic [127:0] key_mod;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] inv_sb [256];

    inv_last_round dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .key_last  (key_last),
        .key_mod   (key_mod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? (8'(x << 1) ^ 8'h1b) : 8'(x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] w;
        w = {b, b} << n;
        return w[15:8];
    endfunction

    // Forward S-box from multiplicative inverse plus affine map, then inverted as a table.
    task automatic build_inv_sbox();
        logic [7:0] inv, s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            inv_sb[s] = 8'(a);
        end
    endtask

    function automatic logic [127:0] ref_round(input logic [127:0] c, input logic [127:0] kl, input logic [127:0] km);
        logic [7:0]   t [16];
        logic [7:0]   s [16];
        logic [7:0]   d;
        logic [127:0] x;
        for (int i = 0; i < 16; i++) t[i] = c[127 - 8*i -: 8] ^ kl[127 - 8*i -: 8];
        for (int cc = 0; cc < 4; cc++)
            for (int r = 0; r < 4; r++)
                s[r + 4*cc] = t[r + 4*((cc - r + 4) % 4)];
        for (int i = 0; i < 16; i++) begin
            d = s[i] - km[127 - 8*i -: 8];
            x[127 - 8*i -: 8] = inv_sb[d];
        end
        return x;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept one block with out_ready low, time its latency, check result, then hand it off.
    task automatic run_block(input string tag, input logic [127:0] c, input logic [127:0] kl,
                             input logic [127:0] km, input logic [127:0] exp);
        int n;
        in_data = c; key_last = kl; key_mod = km; in_valid = 1'b1; out_ready = 1'b0;
        check({tag, " ready_pre"}, 128'(in_ready), 128'(1));
        tick();
        in_valid = 1'b0;
        in_data = rnd128(); key_last = rnd128(); key_mod = rnd128();
        check({tag, " busy"}, 128'(in_ready), 128'(0));
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 128'(n), 128'(5));
        check({tag, " data"}, out_data, exp);
        check({tag, " excl"}, 128'(in_ready), 128'(0));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " drop"}, 128'(out_valid), 128'(0));
        check({tag, " ready_post"}, 128'(in_ready), 128'(1));
    endtask

    initial begin
        logic [127:0] c, kl, km, exp;
        logic [127:0] bc [3];
        logic [127:0] bkl [3];
        logic [127:0] bkm [3];
        int  n, idx_in, handoffs, last_h;
        bit  acc, ho;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; key_last = '0; key_mod = '0; out_ready = 1'b0;
        build_inv_sbox();
        tick(); tick();
        rst = 1'b0;
        check("reset out_valid", 128'(out_valid), 128'(0));
        check("reset in_ready", 128'(in_ready), 128'(1));
        check("reset out_data", out_data, 128'(0));

        run_block("basic", {16{8'h63}}, 128'(0), 128'(0), 128'(0));
        run_block("wrap9d", 128'(0), 128'(0), {16{8'h9d}}, 128'(0));
        run_block("wrap01", {16{8'h64}}, 128'(0), {16{8'h01}}, 128'(0));
        run_block("shift", 128'h001F0000_00000000_00000000_00000000, {16{8'h63}}, 128'(0),
                  128'h00000000_00010000_00000000_00000000);

        for (int k = 0; k < 3; k++) begin
            c = rnd128(); kl = rnd128(); km = rnd128();
            run_block("random", c, kl, km, ref_round(c, kl, km));
        end

        // Backpressure with an ignored in_valid pulse.
        c = rnd128(); kl = rnd128(); km = rnd128(); exp = ref_round(c, kl, km);
        in_data = c; key_last = kl; key_mod = km; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("bp latency", 128'(n), 128'(5));
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin
                in_valid = 1'b1; in_data = rnd128(); key_last = rnd128(); key_mod = rnd128();
            end
            if (k == 6) in_valid = 1'b0;
            tick();
            check("bp hold valid", 128'(out_valid), 128'(1));
            check("bp hold ready", 128'(in_ready), 128'(0));
            check("bp hold data", out_data, exp);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp handoff valid", 128'(out_valid), 128'(0));
        check("bp handoff ready", 128'(in_ready), 128'(1));
        for (int k = 0; k < 8; k++) tick();
        check("bp no ghost valid", 128'(out_valid), 128'(0));
        check("bp no ghost ready", 128'(in_ready), 128'(1));

        // Reset while the column counter is at 2.
        in_data = rnd128(); key_last = rnd128(); key_mod = rnd128(); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst out_valid", 128'(out_valid), 128'(0));
        check("midrst out_data", out_data, 128'(0));
        check("midrst in_ready", 128'(in_ready), 128'(1));
        c = rnd128(); kl = rnd128(); km = rnd128();
        run_block("after_rst", c, kl, km, ref_round(c, kl, km));

        // Back-to-back blocks with both handshakes held high.
        for (int k = 0; k < 3; k++) begin
            bc[k] = rnd128(); bkl[k] = rnd128(); bkm[k] = rnd128();
        end
        idx_in = 0; handoffs = 0; last_h = -1;
        in_data = bc[0]; key_last = bkl[0]; key_mod = bkm[0]; in_valid = 1'b1; out_ready = 1'b1;
        for (int t = 0; t < 60 && handoffs < 3; t++) begin
            acc = in_valid && in_ready;
            ho  = out_valid && out_ready;
            check("b2b exclusive", 128'(out_valid && in_ready), 128'(0));
            if (ho) check("b2b data", out_data, ref_round(bc[handoffs], bkl[handoffs], bkm[handoffs]));
            tick();
            if (ho) begin
                if (handoffs > 0) check("b2b spacing", 128'(cyc - last_h), 128'(7));
                last_h = cyc;
                handoffs++;
            end
            if (acc) begin
                idx_in++;
                if (idx_in < 3) begin
                    in_data = bc[idx_in]; key_last = bkl[idx_in]; key_mod = bkm[idx_in];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("b2b count", 128'(handoffs), 128'(3));
        in_valid = 1'b0; out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
